pipe_trace_buffer: RTL and testbench

Synthesizable, parametrised trace capture unit for the pipelined CPU. Each cycle it snapshots the pipeline-buffer contents of up to NUM_STAGES stages, together with a cycle stamp, into a circular buffer. Capture stops a programmable number of entries after a trigger, such as halt or overflow. The frozen trace is then drained oldest-first through a valid/ready port. This lets the per-cycle pipeline dump run in hardware and on long programs without per-cycle console output.

---
 rtl/pipe_trace_buffer_if.sv | 36 +++
 rtl/pipe_trace_buffer.sv | 113 +++++++++++
 tb/tb_pipe_trace_buffer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_trace_buffer_if.sv
// Signal bundle for pipe_trace_buffer: capture inputs, trigger/arm control,
// drain handshake and status outputs.
interface pipe_trace_buffer_if #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned CYC_W      = 16
);
  localparam int unsigned ENTRY_W = CYC_W + NUM_STAGES + NUM_STAGES * DATA_W;
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

  logic [NUM_STAGES-1:0]        stage_valid;
  logic [NUM_STAGES*DATA_W-1:0] stage_word;
  logic                         cap_all;
  logic                         arm;
  logic                         trigger;
  logic [CNT_W-1:0]             post_count;
  logic                         rd_ready;
  logic                         rd_valid;
  logic [ENTRY_W-1:0]           rd_data;
  logic [CNT_W-1:0]             count;
  logic                         overflow;
  logic [1:0]                   state;
  logic [CYC_W-1:0]             trig_cycle;
  logic [CYC_W-1:0]             cycle_count;

  modport master (
    output stage_valid, stage_word, cap_all, arm, trigger, post_count, rd_ready,
    input  rd_valid, rd_data, count, overflow, state, trig_cycle, cycle_count
  );

  modport slave (
    input  stage_valid, stage_word, cap_all, arm, trigger, post_count, rd_ready,
    output rd_valid, rd_data, count, overflow, state, trig_cycle, cycle_count
  );
endinterface

// File: rtl/pipe_trace_buffer.sv
// Circular trace buffer of per-cycle pipeline snapshots with arm/trigger/post-count
// capture control and an oldest-first valid/ready drain once frozen.
module pipe_trace_buffer #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned CYC_W      = 16
) (
  input logic              clock,
  input logic              reset,
  pipe_trace_buffer_if.slave bus
);
  localparam int unsigned ENTRY_W = CYC_W + NUM_STAGES + NUM_STAGES * DATA_W;
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W   = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    POST   = 2'd2,
    FROZEN = 2'd3
  } state_t;

  state_t             st;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   post_left;
  logic [CNT_W-1:0]   post_clamped;
  logic [CYC_W-1:0]   cyc;
  logic [CYC_W-1:0]   trig_cyc;
  logic               ovf;
  logic               cap;
  logic               pop;
  logic               full;
  logic               rd_valid_i;

  always_comb begin
    // arm pre-empts capture so the clearing cycle never writes an entry
    cap          = (st == ARMED || st == POST) && (bus.cap_all || |bus.stage_valid) && !bus.arm;
    rd_valid_i   = (st == FROZEN) && (cnt != '0);
    pop          = rd_valid_i && bus.rd_ready;
    full         = (cnt == CNT_W'(DEPTH));
    post_clamped = (bus.post_count > CNT_W'(DEPTH - 1)) ? CNT_W'(DEPTH - 1) : bus.post_count;
  end

  always_ff @(posedge clock) begin
    if (cap) begin
      mem[wr_ptr] <= {cyc, bus.stage_valid, bus.stage_word};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st        <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      post_left <= '0;
      cyc       <= '0;
      trig_cyc  <= '0;
      ovf       <= 1'b0;
    end else begin
      cyc <= cyc + CYC_W'(1);
      if (bus.arm) begin
        st        <= ARMED;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        cnt       <= '0;
        post_left <= '0;
        ovf       <= 1'b0;
      end else begin
        if (cap) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
          if (full) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
            ovf    <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end else if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
          cnt    <= cnt - CNT_W'(1);
        end

        case (st)
          ARMED: if (bus.trigger) begin
            trig_cyc  <= cyc;
            post_left <= post_clamped;
            st        <= (post_clamped == '0) ? FROZEN : POST;
          end
          // post_left is at least 1 here; the trigger entry was not counted
          POST: if (cap) begin
            post_left <= post_left - CNT_W'(1);
            if (post_left == CNT_W'(1)) st <= FROZEN;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    bus.rd_valid    = rd_valid_i;
    bus.rd_data     = rd_valid_i ? mem[rd_ptr] : '0;
    bus.count       = cnt;
    bus.overflow    = ovf;
    bus.state       = st;
    bus.trig_cycle  = trig_cyc;
    bus.cycle_count = cyc;
  end
endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Directed bench for pipe_trace_buffer: queue-based reference model compared every
// cycle, plus literal expectations at key points of each scenario.
module tb_pipe_trace_buffer;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned NUM_STAGES = 4;
  localparam int unsigned DEPTH      = 8;
  localparam int unsigned CYC_W      = 16;
  localparam int unsigned ENTRY_W    = CYC_W + NUM_STAGES + NUM_STAGES * DATA_W;

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  pipe_trace_buffer_if #(.DATA_W(DATA_W), .NUM_STAGES(NUM_STAGES), .DEPTH(DEPTH), .CYC_W(CYC_W)) bus ();

  pipe_trace_buffer #(.DATA_W(DATA_W), .NUM_STAGES(NUM_STAGES), .DEPTH(DEPTH), .CYC_W(CYC_W)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: trace as a queue, oldest entry at the front.
  logic [ENTRY_W-1:0] mq[$];
  int                 m_state = 0;
  logic [CYC_W-1:0]   m_cycle = '0;
  logic [CYC_W-1:0]   m_trig  = '0;
  int                 m_post  = 0;
  bit                 m_ovf   = 1'b0;

  always @(posedge clock) begin
    bit do_cap;
    if (reset) begin
      mq.delete();
      m_state = 0; m_cycle = '0; m_trig = '0; m_post = 0; m_ovf = 1'b0;
    end else begin
      do_cap = (m_state == 1 || m_state == 2) && (bus.cap_all || bus.stage_valid != '0);
      if (bus.arm) begin
        mq.delete();
        m_state = 1; m_ovf = 1'b0;
      end else begin
        if (do_cap) begin
          if (mq.size() == DEPTH) begin
            void'(mq.pop_front());
            m_ovf = 1'b1;
          end
          mq.push_back({m_cycle, bus.stage_valid, bus.stage_word});
        end else if (m_state == 3 && mq.size() > 0 && bus.rd_ready) begin
          void'(mq.pop_front());
        end
        if (m_state == 1 && bus.trigger) begin
          m_trig  = m_cycle;
          m_post  = (int'(bus.post_count) > DEPTH - 1) ? DEPTH - 1 : int'(bus.post_count);
          m_state = (m_post == 0) ? 3 : 2;
        end else if (m_state == 2 && do_cap) begin
          m_post--;
          if (m_post == 0) m_state = 3;
        end
      end
      m_cycle = m_cycle + 1'b1;
    end
    #2;
    check("m_state", bus.state, m_state);
    check("m_count", bus.count, mq.size());
    check("m_overflow", bus.overflow, m_ovf);
    check("m_trig_cycle", bus.trig_cycle, m_trig);
    check("m_cycle_count", bus.cycle_count, m_cycle);
    check("m_rd_valid", bus.rd_valid, (m_state == 3 && mq.size() > 0));
    check("m_rd_data", bus.rd_data, (m_state == 3 && mq.size() > 0) ? mq[0] : '0);
  end

  logic [CYC_W-1:0] cyc;
  bit               auto_drive;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      cyc++;
      if (auto_drive) begin
        bus.stage_valid = 4'(cyc * 5);
        bus.stage_word  = {16'(cyc * 3), 16'(cyc + 16'h0100), ~cyc, cyc ^ 16'h5a5a};
      end
    end
  endtask

  function automatic logic [CYC_W-1:0] stamp();
    logic [ENTRY_W-1:0] d;
    d = bus.rd_data;
    return d[ENTRY_W-1 -: CYC_W];
  endfunction

  initial begin
    reset = 1'b1;
    bus.stage_valid = '0; bus.stage_word = '0; bus.cap_all = 1'b0;
    bus.arm = 1'b0; bus.trigger = 1'b0; bus.post_count = '0; bus.rd_ready = 1'b0;
    auto_drive = 1'b0;
    cyc = '0;
    @(posedge clock); @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // reset values
    check("rst_state", bus.state, 0);
    check("rst_count", bus.count, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_trig_cycle", bus.trig_cycle, 0);
    check("rst_cycle_count", bus.cycle_count, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_rd_data", bus.rd_data, 0);
    bus.trigger = 1'b1;
    tick(5);
    bus.trigger = 1'b0;
    check("cycle_after_5", bus.cycle_count, 5);
    check("idle_ignores_trigger", bus.state, 0);

    // basic trigger: arm sampled at cycle 9, ARMED from cycle 10, trigger at 13
    bus.cap_all = 1'b1; bus.post_count = 4'd2; auto_drive = 1'b1;
    tick(4);
    bus.arm = 1'b1; tick(1); bus.arm = 1'b0;
    tick(3);
    bus.trigger = 1'b1; tick(1); bus.trigger = 1'b0;
    check("basic_post_state", bus.state, 2);
    check("basic_post_count", bus.count, 4);
    check("basic_trig_cycle", bus.trig_cycle, 13);
    tick(2);
    check("basic_frozen", bus.state, 3);
    check("basic_count", bus.count, 6);
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("basic_drain_valid", bus.rd_valid, 1);
      check("basic_drain_stamp", stamp(), 10 + i);
      tick(1);
    end
    check("basic_empty_valid", bus.rd_valid, 0);
    check("basic_empty_count", bus.count, 0);
    check("basic_still_frozen", bus.state, 3);
    bus.rd_ready = 1'b0;

    // overflow: captures 23..42 while armed, trigger at 43 with post 0
    bus.post_count = 4'd0;
    bus.arm = 1'b1; tick(1); bus.arm = 1'b0;
    tick(20);
    bus.trigger = 1'b1; tick(1); bus.trigger = 1'b0;
    check("ovf_state", bus.state, 3);
    check("ovf_flag", bus.overflow, 1);
    check("ovf_count", bus.count, 8);
    check("ovf_trig_cycle", bus.trig_cycle, 43);
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("ovf_drain_stamp", stamp(), 36 + i);
      tick(1);
    end
    bus.rd_ready = 1'b0;
    check("ovf_drained", bus.rd_valid, 0);

    // valid gating: only the 0101 cycle (stamp 56) is captured, trigger at 57
    bus.cap_all = 1'b0; auto_drive = 1'b0;
    bus.stage_valid = '0; bus.stage_word = '0;
    bus.arm = 1'b1; tick(1); bus.arm = 1'b0;
    tick(3);
    check("gate_none", bus.count, 0);
    bus.stage_valid = 4'b0101;
    bus.stage_word  = {16'h2222, 16'hBBBB, 16'h1111, 16'hAAAA};
    tick(1);
    bus.stage_valid = '0; bus.stage_word = '0;
    bus.trigger = 1'b1; tick(1); bus.trigger = 1'b0;
    check("gate_count", bus.count, 1);
    check("gate_state", bus.state, 3);
    check("gate_trig_cycle", bus.trig_cycle, 57);
    check("gate_entry", bus.rd_data, {16'd56, 4'b0101, 64'h2222_BBBB_1111_AAAA});

    // arm and trigger together: arm wins
    bus.arm = 1'b1; bus.trigger = 1'b1; bus.cap_all = 1'b1; auto_drive = 1'b1;
    bus.post_count = 4'd3;
    tick(1);
    bus.arm = 1'b0; bus.trigger = 1'b0;
    check("prio_state", bus.state, 1);
    check("prio_trig_kept", bus.trig_cycle, 57);
    check("prio_count", bus.count, 0);
    tick(10);
    check("prio_ovf_count", bus.count, 8);
    bus.trigger = 1'b1; tick(1);
    check("prio_post", bus.state, 2);
    check("prio_trig_cycle", bus.trig_cycle, 69);
    tick(1); bus.trigger = 1'b0;
    check("post_trig_ignored", bus.trig_cycle, 69);
    check("post_state_kept", bus.state, 2);
    tick(2);
    check("prio_frozen", bus.state, 3);
    check("prio_frozen_ovf", bus.overflow, 1);
    bus.rd_ready = 1'b1; tick(5); bus.rd_ready = 1'b0;
    check("prio_left3", bus.count, 3);
    bus.arm = 1'b1; tick(1); bus.arm = 1'b0;
    check("rearm_count", bus.count, 0);
    check("rearm_ovf", bus.overflow, 0);
    check("rearm_state", bus.state, 1);

    // reset during POST; post_count 12 clamps to 7 so POST persists
    bus.post_count = 4'd12;
    tick(3);
    bus.trigger = 1'b1; tick(1); bus.trigger = 1'b0;
    check("mid_post_count", bus.count, 4);
    check("mid_post_state", bus.state, 2);
    reset = 1'b1;
    #1;
    check("async_count", bus.count, 0);
    check("async_state", bus.state, 0);
    check("async_rd_valid", bus.rd_valid, 0);
    check("async_cycle", bus.cycle_count, 0);
    @(negedge clock);
    reset = 1'b0;
    cyc = '0;
    tick(4);
    check("post_reset_cycle", bus.cycle_count, 4);
    check("post_reset_state", bus.state, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
